// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered split-panel pixel store, bank swap on frame end.
// Define LED_FB_CLEAR_EN to zero the new back bank after every swap.
module led_frame_buffer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W:0]   wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrReady,
  input  logic              swapReq,
  input  logic              done,
  input  logic [ADDR_W-1:0] pixelAddress0,
  input  logic [ADDR_W-1:0] pixelAddress1,
  output logic [DATA_W-1:0] pixel0,
  output logic [DATA_W-1:0] pixel1,
  output logic              swapPending,
  output logic              frontSel,
  output logic [7:0]        frameCount
);
  localparam int DEPTH = 2 ** (ADDR_W + 1);

`ifdef LED_FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];

  logic              w_swap;
  logic              w_memWe;
  logic [ADDR_W:0]   w_memAddr;
  logic [DATA_W-1:0] w_memData;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;

  assign w_swap = (r_state == PENDING) && done;

`ifdef LED_FB_CLEAR_EN
  localparam logic [ADDR_W:0] PTR_ONE = 1;
  logic [ADDR_W:0] r_clrPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_clrPtr <= '0;
    else if (r_state == CLEAR)
      r_clrPtr <= r_clrPtr + PTR_ONE;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:
        if (swapReq) w_next = PENDING;
      PENDING:
`ifdef LED_FB_CLEAR_EN
        if (done) w_next = CLEAR;
      CLEAR:
        if (r_clrPtr == '1) w_next = IDLE;
`else
        if (done) w_next = IDLE;
`endif
      default:
        w_next = IDLE;
    endcase
  end

  always_comb begin
    wrReady     = 1'b0;
    swapPending = 1'b0;
    case (r_state)
      IDLE:    wrReady     = 1'b1;
      PENDING: swapPending = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frontSel   <= 1'b0;
      frameCount <= 8'd0;
    end else if (w_swap) begin
      frontSel   <= ~frontSel;
      frameCount <= frameCount + 8'd1;
    end
  end

  // The clear walker borrows the CPU write port; CPU writes are refused meanwhile.
`ifdef LED_FB_CLEAR_EN
  assign w_memWe   = (wrEn && wrReady) || (r_state == CLEAR);
  assign w_memAddr = (r_state == CLEAR) ? r_clrPtr : wrAddr;
  assign w_memData = (r_state == CLEAR) ? '0 : wrData;
`else
  assign w_memWe   = wrEn && wrReady;
  assign w_memAddr = wrAddr;
  assign w_memData = wrData;
`endif

  always_ff @(posedge clk) begin
    if (w_memWe && frontSel)
      r_bank0[w_memAddr] <= w_memData;
    if (w_memWe && !frontSel)
      r_bank1[w_memAddr] <= w_memData;
  end

  assign w_rd0 = frontSel ? r_bank1[{1'b0, pixelAddress0}]
                          : r_bank0[{1'b0, pixelAddress0}];
  assign w_rd1 = frontSel ? r_bank1[{1'b1, pixelAddress1}]
                          : r_bank0[{1'b1, pixelAddress1}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel0 <= '0;
      pixel1 <= '0;
    end else begin
      pixel0 <= w_rd0;
      pixel1 <= w_rd1;
    end
  end

endmodule
